// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types: bus profile, command/response encodings and the
// command-classification helpers used by responders.
package pzcorebus_pkg;

    typedef struct packed {
        int id_width;
        int address_width;
        int data_width;
        int unit_data_width;
        int max_length;
        int request_info_width;
        int response_info_width;
    } pzcorebus_config;

    localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
        id_width:            8,
        address_width:       32,
        data_width:          128,
        unit_data_width:     32,
        max_length:          256,
        request_info_width:  1,
        response_info_width: 1
    };

    typedef enum logic [2:0] {
        PZCOREBUS_NULL_COMMAND       = 3'd0,
        PZCOREBUS_READ               = 3'd1,
        PZCOREBUS_WRITE              = 3'd2,
        PZCOREBUS_WRITE_NON_POSTED   = 3'd3,
        PZCOREBUS_BROADCAST          = 3'd4,
        PZCOREBUS_ATOMIC             = 3'd5,
        PZCOREBUS_ATOMIC_NON_POSTED  = 3'd6,
        PZCOREBUS_MESSAGE            = 3'd7
    } pzcorebus_command_type;

    typedef enum logic [1:0] {
        PZCOREBUS_NULL_RESPONSE      = 2'd0,
        PZCOREBUS_RESPONSE           = 2'd1,
        PZCOREBUS_RESPONSE_WITH_DATA = 2'd2
    } pzcorebus_response_type;

    function automatic int get_length_width(pzcorebus_config cfg);
        return (cfg.max_length > 1) ? $clog2(cfg.max_length) : 1;
    endfunction

    function automatic int get_unit_enable_width(pzcorebus_config cfg);
        return cfg.data_width / cfg.unit_data_width;
    endfunction

    function automatic bit is_command_with_data(pzcorebus_command_type cmd);
        case (cmd)
            PZCOREBUS_WRITE,
            PZCOREBUS_WRITE_NON_POSTED,
            PZCOREBUS_BROADCAST,
            PZCOREBUS_ATOMIC,
            PZCOREBUS_ATOMIC_NON_POSTED: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic bit is_non_posted_command(pzcorebus_command_type cmd);
        case (cmd)
            PZCOREBUS_READ,
            PZCOREBUS_WRITE_NON_POSTED,
            PZCOREBUS_ATOMIC_NON_POSTED: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    // Commands whose response carries read data (plain reads and atomic-reads).
    function automatic bit is_response_with_data(pzcorebus_command_type cmd);
        case (cmd)
            PZCOREBUS_READ,
            PZCOREBUS_ATOMIC_NON_POSTED: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    // mlength==0 encodes MAX_LENGTH words; beats round up to whole bus words.
    function automatic int get_response_beats(pzcorebus_config cfg, int mlength);
        int words;
        int wpb;
        words = (mlength == 0) ? cfg.max_length : mlength;
        wpb   = cfg.data_width / cfg.unit_data_width;
        return (words + wpb - 1) / wpb;
    endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus channel bundle: command, write data and response channels with
// valid/accept handshakes, sized from a single bus profile.
interface pzcorebus_if
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG
);
    localparam int ID_WIDTH     = BUS_CONFIG.id_width;
    localparam int ADDR_WIDTH   = BUS_CONFIG.address_width;
    localparam int DATA_WIDTH   = BUS_CONFIG.data_width;
    localparam int LENGTH_WIDTH = get_length_width(BUS_CONFIG);
    localparam int UE_WIDTH     = get_unit_enable_width(BUS_CONFIG);
    localparam int BE_WIDTH     = BUS_CONFIG.data_width / 8;
    localparam int RQI_WIDTH    = BUS_CONFIG.request_info_width;
    localparam int RSI_WIDTH    = BUS_CONFIG.response_info_width;

    logic                   mcmd_valid;
    logic                   scmd_accept;
    pzcorebus_command_type  mcmd;
    logic [ID_WIDTH-1:0]    mid;
    logic [ADDR_WIDTH-1:0]  maddr;
    logic [LENGTH_WIDTH-1:0] mlength;
    logic [RQI_WIDTH-1:0]   minfo;
    logic                   mdata_valid;
    logic                   sdata_accept;
    logic [DATA_WIDTH-1:0]  mdata;
    logic [BE_WIDTH-1:0]    mdata_byteen;
    logic                   mdata_last;
    logic                   sresp_valid;
    logic                   mresp_accept;
    pzcorebus_response_type sresp;
    logic [ID_WIDTH-1:0]    sid;
    logic                   serror;
    logic [DATA_WIDTH-1:0]  sdata;
    logic [RSI_WIDTH-1:0]   sinfo;
    logic [UE_WIDTH-1:0]    sresp_uniten;
    logic                   sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        output mdata_valid, mdata, mdata_byteen, mdata_last,
        output mresp_accept,
        input  scmd_accept, sdata_accept,
        input  sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        input  mdata_valid, mdata, mdata_byteen, mdata_last,
        input  mresp_accept,
        output scmd_accept, sdata_accept,
        output sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last
    );

endinterface

// File: rtl/pzcorebus_error_slave.sv
// Default pzcorebus target: accepts every command, sinks write data, answers non-posted commands with error responses.
// Latency: first response beat 1 cycle after the command (read) or mdata_last (write) handshake; one transaction outstanding.
// Backpressure: mresp_accept stalls the response with fields held; commands and data are refused while busy.
module pzcorebus_error_slave
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config              BUS_CONFIG   = PZCOREBUS_DEFAULT_CONFIG,
    parameter bit                           SERROR_VALUE = 1'b1,
    parameter logic [BUS_CONFIG.data_width-1:0] SDATA_VALUE = '0
)(
    input logic         i_clk,
    input logic         i_rst,
    pzcorebus_if.slave  slave_if
);

    localparam int ID_WIDTH = BUS_CONFIG.id_width;
    localparam int CW       = $clog2(BUS_CONFIG.max_length) + 1;
    localparam int UE_WIDTH = get_unit_enable_width(BUS_CONFIG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                 state;
    logic                   cmd_accept;
    logic                   data_accept;
    logic                   resp_valid;
    logic                   resp_last;
    logic                   non_posted;
    logic [CW-1:0]          resp_count;
    logic [ID_WIDTH-1:0]    resp_id;
    pzcorebus_response_type resp_type;

    logic                   data_last_ack;
    logic                   resp_ack;
    logic                   cmd_with_rdata;
    logic [CW-1:0]          cmd_beats;

    assign data_last_ack  = slave_if.mdata_valid && data_accept && slave_if.mdata_last;
    assign resp_ack       = resp_valid && slave_if.mresp_accept;
    assign cmd_with_rdata = is_response_with_data(slave_if.mcmd);
    // Write-type responses are a single beat regardless of mlength.
    assign cmd_beats      = cmd_with_rdata
                          ? CW'(get_response_beats(BUS_CONFIG, int'(slave_if.mlength)))
                          : CW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cmd_accept  <= 1'b0;
            data_accept <= 1'b0;
            resp_valid  <= 1'b0;
            resp_last   <= 1'b0;
            non_posted  <= 1'b0;
            resp_count  <= '0;
            resp_id     <= '0;
            resp_type   <= PZCOREBUS_NULL_RESPONSE;
        end else begin
            case (state)
                IDLE: begin
                    if (!cmd_accept) begin
                        cmd_accept <= 1'b1;
                    end else if (slave_if.mcmd_valid) begin
                        cmd_accept <= 1'b0;
                        resp_id    <= slave_if.mid;
                        non_posted <= is_non_posted_command(slave_if.mcmd);
                        resp_type  <= cmd_with_rdata ? PZCOREBUS_RESPONSE_WITH_DATA
                                                     : PZCOREBUS_RESPONSE;
                        resp_count <= cmd_beats;
                        resp_last  <= (cmd_beats == CW'(1));
                        if (is_command_with_data(slave_if.mcmd)) begin
                            data_accept <= 1'b1;
                            state       <= DATA;
                        end else if (is_non_posted_command(slave_if.mcmd)) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                DATA: begin
                    if (data_last_ack) begin
                        data_accept <= 1'b0;
                        if (non_posted) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            cmd_accept <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (resp_ack) begin
                        if (resp_last) begin
                            resp_valid <= 1'b0;
                            resp_last  <= 1'b0;
                            resp_type  <= PZCOREBUS_NULL_RESPONSE;
                            cmd_accept <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            resp_count <= resp_count - CW'(1);
                            resp_last  <= (resp_count == CW'(2));
                        end
                    end
                end
                default: begin
                    cmd_accept  <= 1'b0;
                    data_accept <= 1'b0;
                    resp_valid  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign slave_if.scmd_accept  = cmd_accept;
    assign slave_if.sdata_accept = data_accept;
    assign slave_if.sresp_valid  = resp_valid;
    assign slave_if.sresp        = resp_type;
    assign slave_if.sid          = resp_id;
    assign slave_if.serror       = SERROR_VALUE;
    assign slave_if.sdata        = (resp_type == PZCOREBUS_RESPONSE_WITH_DATA) ? SDATA_VALUE : '0;
    assign slave_if.sinfo        = '0;
    assign slave_if.sresp_uniten = {UE_WIDTH{1'b1}};
    assign slave_if.sresp_last   = resp_last;

endmodule

// File: tb/tb_pzcorebus_error_slave.sv
// Directed and randomized checks of pzcorebus_error_slave on a 128-bit bus
// (32-bit units, MAX_LENGTH 256) against a length/command-class model.
module tb_pzcorebus_error_slave;
    import pzcorebus_pkg::*;

    localparam pzcorebus_config CFG = '{
        id_width:            8,
        address_width:       32,
        data_width:          128,
        unit_data_width:     32,
        max_length:          256,
        request_info_width:  4,
        response_info_width: 4
    };

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pzcorebus_if #(.BUS_CONFIG(CFG)) bus_if ();

    pzcorebus_error_slave #(
        .BUS_CONFIG   (CFG),
        .SERROR_VALUE (1'b1),
        .SDATA_VALUE  ('0)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .slave_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference classification taken directly from the command semantics.
    function automatic bit m_has_wdata(pzcorebus_command_type c);
        return c == PZCOREBUS_WRITE || c == PZCOREBUS_WRITE_NON_POSTED || c == PZCOREBUS_BROADCAST
            || c == PZCOREBUS_ATOMIC || c == PZCOREBUS_ATOMIC_NON_POSTED;
    endfunction

    function automatic bit m_non_posted(pzcorebus_command_type c);
        return c == PZCOREBUS_READ || c == PZCOREBUS_WRITE_NON_POSTED || c == PZCOREBUS_ATOMIC_NON_POSTED;
    endfunction

    function automatic bit m_rdata(pzcorebus_command_type c);
        return c == PZCOREBUS_READ || c == PZCOREBUS_ATOMIC_NON_POSTED;
    endfunction

    function automatic int m_beats(pzcorebus_command_type c, int len);
        int words;
        if (!m_rdata(c)) return 1;
        words = (len == 0) ? 256 : len;
        return (words + 3) / 4;
    endfunction

    // Returns positioned one cycle after the command handshake edge.
    task automatic send_cmd(input pzcorebus_command_type cmd, input logic [7:0] id, input logic [7:0] len);
        int g;
        g = 0;
        bus_if.mcmd_valid = 1'b1;
        bus_if.mcmd       = cmd;
        bus_if.mid        = id;
        bus_if.mlength    = len;
        bus_if.maddr      = $urandom;
        bus_if.minfo      = 4'($urandom);
        while (!bus_if.scmd_accept && g < 100) begin
            tick();
            g++;
        end
        check("cmd_accept_bound", 128'(g < 100), 128'd1);
        tick();
        bus_if.mcmd_valid = 1'b0;
    endtask

    task automatic send_data(input int n, input bit gap);
        int g;
        for (int b = 0; b < n; b++) begin
            if (gap) begin
                bus_if.mdata_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            bus_if.mdata_valid  = 1'b1;
            bus_if.mdata        = {$urandom, $urandom, $urandom, $urandom};
            bus_if.mdata_byteen = 16'($urandom);
            bus_if.mdata_last   = (b == n - 1);
            g = 0;
            while (!bus_if.sdata_accept && g < 100) begin
                tick();
                g++;
            end
            check("data_accept_bound", 128'(g < 100), 128'd1);
            tick();
        end
        bus_if.mdata_valid = 1'b0;
        bus_if.mdata_last  = 1'b0;
    endtask

    // mode 0: always accept, 1: random accept, 2: hold accept low 5 cycles before beat 1
    task automatic collect_resp(input logic [7:0] id, input int beats, input bit rdata, input int mode);
        int   beat;
        int   g;
        int   stall_cnt;
        bit   acc;
        bit   held;
        logic [7:0] h_sid;
        logic       h_last;
        logic [1:0] h_resp;
        beat = 0; g = 0; stall_cnt = 0; held = 0;
        h_sid = '0; h_last = 0; h_resp = '0;
        while (beat < beats && g < 2000) begin
            case (mode)
                0:       acc = 1'b1;
                1:       acc = ($urandom_range(0, 2) != 0);
                default: acc = !(beat == 1 && stall_cnt < 5);
            endcase
            bus_if.mresp_accept = acc;
            if (held) begin
                check("hold_valid", 128'(bus_if.sresp_valid), 128'd1);
                check("hold_sid", 128'(bus_if.sid), 128'(h_sid));
                check("hold_last", 128'(bus_if.sresp_last), 128'(h_last));
                check("hold_sresp", 128'(bus_if.sresp), 128'(h_resp));
            end
            held = 0;
            if (bus_if.sresp_valid) begin
                check("sid", 128'(bus_if.sid), 128'(id));
                check("serror", 128'(bus_if.serror), 128'd1);
                check("sresp", 128'(bus_if.sresp),
                      128'(rdata ? PZCOREBUS_RESPONSE_WITH_DATA : PZCOREBUS_RESPONSE));
                check("sresp_last", 128'(bus_if.sresp_last), 128'(beat == beats - 1));
                if (rdata) check("sdata", bus_if.sdata, 128'd0);
                if (acc) begin
                    beat++;
                end else begin
                    held   = 1;
                    h_sid  = bus_if.sid;
                    h_last = bus_if.sresp_last;
                    h_resp = bus_if.sresp;
                    if (beat == 1) stall_cnt++;
                end
            end
            tick();
            g++;
        end
        bus_if.mresp_accept = 1'b0;
        check("resp_bound", 128'(g < 2000), 128'd1);
        check("resp_done_valid", 128'(bus_if.sresp_valid), 128'd0);
    endtask

    task automatic do_txn(input pzcorebus_command_type cmd, input logic [7:0] id,
                          input logic [7:0] len, input int mode);
        send_cmd(cmd, id, len);
        if (m_has_wdata(cmd)) begin
            check("no_resp_during_data", 128'(bus_if.sresp_valid), 128'd0);
            send_data($urandom_range(1, 4), 1'b1);
        end
        if (m_non_posted(cmd)) begin
            check("first_resp_latency", 128'(bus_if.sresp_valid), 128'd1);
            collect_resp(id, m_beats(cmd, int'(len)), m_rdata(cmd), mode);
        end else begin
            check("posted_no_resp", 128'(bus_if.sresp_valid), 128'd0);
            tick();
            check("posted_no_resp_2", 128'(bus_if.sresp_valid), 128'd0);
        end
    endtask

    initial begin
        pzcorebus_command_type cmds[6];
        pzcorebus_command_type c;
        logic [7:0] id;
        logic [7:0] len;
        n_cmp = 0;
        n_err = 0;
        cmds = '{PZCOREBUS_READ, PZCOREBUS_WRITE, PZCOREBUS_WRITE_NON_POSTED,
                 PZCOREBUS_MESSAGE, PZCOREBUS_ATOMIC, PZCOREBUS_ATOMIC_NON_POSTED};

        rst                 = 1'b1;
        bus_if.mcmd_valid   = 1'b0;
        bus_if.mcmd         = PZCOREBUS_NULL_COMMAND;
        bus_if.mid          = '0;
        bus_if.maddr        = '0;
        bus_if.mlength      = '0;
        bus_if.minfo        = '0;
        bus_if.mdata_valid  = 1'b0;
        bus_if.mdata        = '0;
        bus_if.mdata_byteen = '0;
        bus_if.mdata_last   = 1'b0;
        bus_if.mresp_accept = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_scmd_accept", 128'(bus_if.scmd_accept), 128'd0);
        check("rst_sdata_accept", 128'(bus_if.sdata_accept), 128'd0);
        check("rst_sresp_valid", 128'(bus_if.sresp_valid), 128'd0);
        check("rst_sresp", 128'(bus_if.sresp), 128'(PZCOREBUS_NULL_RESPONSE));
        check("rst_sresp_last", 128'(bus_if.sresp_last), 128'd0);
        check("rst_sid", 128'(bus_if.sid), 128'd0);
        check("rst_sinfo", 128'(bus_if.sinfo), 128'd0);
        rst = 1'b0;
        check("post_rst_accept_low", 128'(bus_if.scmd_accept), 128'd0);
        tick();
        check("post_rst_accept_high", 128'(bus_if.scmd_accept), 128'd1);
        check("uniten", 128'(bus_if.sresp_uniten), 128'hF);

        // 1: READ mid=5 len=8 -> 2 beats
        do_txn(PZCOREBUS_READ, 8'd5, 8'd8, 0);

        // 2: READ len=0 -> 64 beats; len=5 -> 2 beats
        do_txn(PZCOREBUS_READ, 8'd6, 8'd0, 0);
        do_txn(PZCOREBUS_READ, 8'd7, 8'd5, 0);

        // 3: non-posted write, gapped data, single response beat
        do_txn(PZCOREBUS_WRITE_NON_POSTED, 8'd3, 8'd12, 0);

        // 4: data offered before any command is refused
        bus_if.mdata_valid = 1'b1;
        bus_if.mdata_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("early_data_refused", 128'(bus_if.sdata_accept), 128'd0);
            tick();
        end
        send_cmd(PZCOREBUS_WRITE, 8'd11, 8'd8);
        check("posted_data_accept", 128'(bus_if.sdata_accept), 128'd1);
        tick();
        bus_if.mdata_last = 1'b1;
        tick();
        bus_if.mdata_valid = 1'b0;
        bus_if.mdata_last  = 1'b0;
        check("posted_wr_no_resp", 128'(bus_if.sresp_valid), 128'd0);
        check("posted_data_done", 128'(bus_if.sdata_accept), 128'd0);
        check("read_after_write_accept", 128'(bus_if.scmd_accept), 128'd1);
        send_cmd(PZCOREBUS_READ, 8'd12, 8'd12);
        check("read_after_write_resp", 128'(bus_if.sresp_valid), 128'd1);
        collect_resp(8'd12, 3, 1'b1, 0);

        // Posted command without data: 2 cycles per command
        bus_if.mcmd_valid = 1'b1;
        bus_if.mcmd       = PZCOREBUS_MESSAGE;
        bus_if.mid        = 8'd20;
        check("msg_accept_1", 128'(bus_if.scmd_accept), 128'd1);
        tick();
        check("msg_gap", 128'(bus_if.scmd_accept), 128'd0);
        tick();
        check("msg_accept_2", 128'(bus_if.scmd_accept), 128'd1);
        tick();
        bus_if.mcmd_valid = 1'b0;
        check("msg_no_resp", 128'(bus_if.sresp_valid), 128'd0);
        tick();

        // 5: stalled burst keeps fields stable
        do_txn(PZCOREBUS_READ, 8'd8, 8'd16, 2);

        // 5b: reset during beat 2 drops the transaction
        send_cmd(PZCOREBUS_READ, 8'd9, 8'd16);
        bus_if.mresp_accept = 1'b1;
        tick();
        bus_if.mresp_accept = 1'b0;
        check("mid_burst_valid", 128'(bus_if.sresp_valid), 128'd1);
        check("mid_burst_not_last", 128'(bus_if.sresp_last), 128'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 128'(bus_if.sresp_valid), 128'd0);
        check("async_rst_accept", 128'(bus_if.scmd_accept), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        check("after_rst_valid", 128'(bus_if.sresp_valid), 128'd0);
        check("after_rst_accept", 128'(bus_if.scmd_accept), 128'd1);
        do_txn(PZCOREBUS_READ, 8'd10, 8'd4, 0);

        // Randomized mix
        for (int k = 0; k < 30; k++) begin
            c   = cmds[$urandom_range(0, 5)];
            id  = 8'($urandom);
            len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            do_txn(c, id, len, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
